// File: rtl/full_adder_64_pkg.sv
// Shared constants for the registered 64-bit lookahead adder.
// Width default and lookahead group size.
package full_adder_64_pkg;

  localparam int FA_WIDTH = 64;
  localparam int FA_GROUP = 4;

endpackage

// File: rtl/full_adder_64_cla4.sv
// 4-bit carry-lookahead adder group.
// Also exports the carry into bit 3 so the top can form overflow.
module full_adder_64_cla4
  import full_adder_64_pkg::*;
(
  input  logic [FA_GROUP-1:0] a_i,
  input  logic [FA_GROUP-1:0] b_i,
  input  logic                cin_i,
  output logic [FA_GROUP-1:0] s_o,
  output logic                cout_o,
  output logic                c3_o
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  assign c[0] = cin_i;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0])
              | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign s_o    = p ^ c[3:0];
  assign cout_o = c[4];
  assign c3_o   = c[3];

endmodule

// File: rtl/full_adder_64.sv
// Registered adder: WIDTH/4 lookahead groups with rippled group
// carries, followed by one output register stage.
module full_adder_64
  import full_adder_64_pkg::*;
#(
  parameter int WIDTH = FA_WIDTH
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             CarryIn,
  output logic [WIDTH-1:0] Sum,
  output logic             CarryOut,
  output logic             Overflow
);

  localparam int NG = WIDTH / FA_GROUP;

  logic [NG:0]      gc;
  logic [NG-1:0]    c3;
  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] sum_q;
  logic             co_d;
  logic             co_q;
  logic             ov_d;
  logic             ov_q;
  logic             unused_c3;

  assign gc[0] = CarryIn;

  for (genvar gi = 0; gi < NG; gi++) begin : g_grp
    full_adder_64_cla4 u_cla4 (
      .a_i    (X[gi*FA_GROUP +: FA_GROUP]),
      .b_i    (Y[gi*FA_GROUP +: FA_GROUP]),
      .cin_i  (gc[gi]),
      .s_o    (sum_d[gi*FA_GROUP +: FA_GROUP]),
      .cout_o (gc[gi+1]),
      .c3_o   (c3[gi])
    );
  end

  // Only the top group's bit-3 carry feeds overflow.
  assign unused_c3 = ^c3;

  assign co_d = gc[NG];
  assign ov_d = c3[NG-1] ^ gc[NG];

  always_ff @(posedge Clock) begin
    if (Reset) begin
      sum_q <= '0;
      co_q  <= 1'b0;
      ov_q  <= 1'b0;
    end else begin
      sum_q <= sum_d;
      co_q  <= co_d;
      ov_q  <= ov_d;
    end
  end

  assign Sum      = sum_q;
  assign CarryOut = co_q;
  assign Overflow = ov_q;

endmodule

// File: tb/tb_full_adder_64.sv
// Directed and random checks of the registered 64-bit adder.
// Results compared as {Overflow, CarryOut, Sum}.
module tb_full_adder_64;

  localparam int W = 64;

  logic         Clock = 1'b0;
  logic         Reset;
  logic [W-1:0] X;
  logic [W-1:0] Y;
  logic         CarryIn;
  logic [W-1:0] Sum;
  logic         CarryOut;
  logic         Overflow;

  int n_eval = 0;
  int n_fail = 0;

  full_adder_64 #(.WIDTH(W)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .X        (X),
    .Y        (Y),
    .CarryIn  (CarryIn),
    .Sum      (Sum),
    .CarryOut (CarryOut),
    .Overflow (Overflow)
  );

  always #5 Clock = ~Clock;

  function automatic logic [W+1:0] ref_add(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic         c
  );
    logic [W:0] r;
    logic       ov;
    r  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    ov = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
    return {ov, r};
  endfunction

  task automatic chk(
    input string          tag,
    input logic [W+1:0]   exp
  );
    logic [W+1:0] obs;
    obs = {Overflow, CarryOut, Sum};
    n_eval++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(
    input logic         rst,
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic         c
  );
    Reset   = rst;
    X       = a;
    Y       = b;
    CarryIn = c;
    @(posedge Clock);
    #1;
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;

    Reset = 1'b1; X = '0; Y = '0; CarryIn = 1'b0;
    #2;

    step(1'b1, 64'd5, 64'd7, 1'b0);
    chk("reset_5_7", {1'b0, 1'b0, 64'd0});

    step(1'b0, 64'd4, 64'd1, 1'b0);
    chk("add_4_1", {1'b0, 1'b0, 64'd5});

    for (int i = 0; i <= 6; i++) begin
      step(1'b0, 64'(i), 64'd1, 1'b0);
      chk($sformatf("b2b_%0d", i), {2'b00, 64'(i + 1)});
    end

    // Inputs changed between edges must not disturb held outputs.
    X = 64'd100; Y = 64'd200; CarryIn = 1'b1;
    #3;
    chk("hold_between_edges", {2'b00, 64'd7});
    @(posedge Clock);
    #1;
    chk("hold_then_add", {2'b00, 64'd301});

    step(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
    chk("wrap_ones_cin", {1'b0, 1'b1, 64'd0});

    step(1'b0, 64'h8000_0000_0000_0000,
         64'h8000_0000_0000_0000, 1'b0);
    chk("neg_overflow", {1'b1, 1'b1, 64'd0});

    step(1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    chk("pos_overflow",
        {1'b1, 1'b0, 64'h8000_0000_0000_0000});

    step(1'b0, 64'hFFFF_FFFF_FFFF_FFFF,
         64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    chk("ones_ones_cin",
        {1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF});

    step(1'b0, 64'h0F0F_0F0F_0F0F_0F0F,
         64'h00F0_00F0_00F0_00F0, 1'b1);
    chk("group_pattern",
        {1'b0, 1'b0, 64'h0FFF_0FFF_0FFF_1000});

    step(1'b0, 64'd10, 64'd20, 1'b0);
    chk("stream_a", {2'b00, 64'd30});
    step(1'b0, 64'd11, 64'd21, 1'b1);
    chk("stream_b", {2'b00, 64'd33});
    step(1'b0, 64'd12, 64'd22, 1'b0);
    chk("stream_c", {2'b00, 64'd34});

    step(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
    chk("mid_reset", {1'b0, 1'b0, 64'd0});

    step(1'b0, 64'd9, 64'd8, 1'b1);
    chk("after_reset", {2'b00, 64'd18});

    for (int i = 0; i < 10000; i++) begin
      ra = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()};
      rc = 1'($urandom_range(1, 0));
      step(1'b0, ra, rb, rc);
      chk("random", ref_add(ra, rb, rc));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_eval, n_fail);
    $finish;
  end

endmodule
